// File: rtl/int_ctrl_if.sv
// Bundles the interrupt controller's source, config, pipeline-status and PC-request signals.
// master = core/testbench side, slave = int_ctrl.
interface int_ctrl_if #(
    parameter int unsigned NUM_SRC = 8
);
    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] irq_in;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [7:0]         cfg_wdata;
    logic [7:0]         cfg_rdata;
    logic               hazard;
    logic               branch_hazard;
    logic               pipeline_flush;
    logic               p_cache_miss;
    logic               RET;
    logic               interrupt;
    logic [IDX_W-1:0]   int_addr;
    logic               in_service;

    modport master (
        output irq_in, cfg_we, cfg_addr, cfg_wdata,
        output hazard, branch_hazard, pipeline_flush, p_cache_miss, RET,
        input  cfg_rdata, interrupt, int_addr, in_service
    );

    modport slave (
        input  irq_in, cfg_we, cfg_addr, cfg_wdata,
        input  hazard, branch_hazard, pipeline_flush, p_cache_miss, RET,
        output cfg_rdata, interrupt, int_addr, in_service
    );
endinterface

// File: rtl/int_ctrl.sv
// Non-nesting priority interrupt controller: synchronizes sources, tracks pending state,
// and issues a one-cycle vectored request to the PC when the fetch pipeline is quiet.
module int_ctrl #(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    int_ctrl_if.slave   bus
);

    localparam int unsigned IDX_W     = $clog2(NUM_SRC);
    localparam logic [1:0]  ADDR_MASK = 2'd0;
    localparam logic [1:0]  ADDR_EDGE = 2'd1;
    localparam logic [1:0]  ADDR_PEND = 2'd2;
    localparam logic [1:0]  ADDR_CTRL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SERVICE,
        ST_GUARD
    } state_t;

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] r_sync;
    logic [NUM_SRC-1:0] r_s_d;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_edge_mode;
    logic               r_gie;
    state_t             r_state;
    logic               r_interrupt;
    logic               r_in_service;
    logic [IDX_W-1:0]   r_int_addr;

    logic [NUM_SRC-1:0] w_s;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic [NUM_SRC-1:0] w_eligible;
    logic [IDX_W-1:0]   w_winner;
    logic               w_inhibit;
    logic               w_grant;
    logic               w_ret;

    // Input synchronizer chain plus one-cycle delay for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_s_d  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.irq_in};
            r_s_d  <= w_s;
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;

    // Edge bits: a new rising edge beats any clear landing in the same cycle
    always_comb begin
        w_clr = '0;
        if (bus.cfg_we && (bus.cfg_addr == ADDR_PEND)) begin
            w_clr = bus.cfg_wdata;
        end
        if (r_state == ST_ISSUE) begin
            w_clr[r_int_addr] = 1'b1;
        end
        w_pending_nxt = (r_edge_mode & (w_rise | (r_pending & ~w_clr)))
                      | (~r_edge_mode & w_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask      <= '0;
            r_edge_mode <= '0;
            r_gie       <= 1'b0;
        end else if (bus.cfg_we) begin
            case (bus.cfg_addr)
                ADDR_MASK: r_mask      <= bus.cfg_wdata;
                ADDR_EDGE: r_edge_mode <= bus.cfg_wdata;
                ADDR_CTRL: r_gie       <= bus.cfg_wdata[0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            ADDR_MASK: bus.cfg_rdata = r_mask;
            ADDR_EDGE: bus.cfg_rdata = r_edge_mode;
            ADDR_PEND: bus.cfg_rdata = r_pending;
            ADDR_CTRL: bus.cfg_rdata = {7'b0, r_gie};
            default:   bus.cfg_rdata = '0;
        endcase
    end

    // Lowest index wins
    assign w_eligible = r_pending & r_mask;

    always_comb begin
        w_winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = IDX_W'(i);
            end
        end
    end

    assign w_inhibit = bus.hazard | bus.branch_hazard | bus.pipeline_flush
                     | bus.p_cache_miss | bus.RET;
    assign w_grant   = r_gie & (|w_eligible) & ~w_inhibit;
    assign w_ret     = bus.RET & ~bus.branch_hazard;

    // Grant/service sequencer; outputs are registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_interrupt  <= 1'b0;
            r_in_service <= 1'b0;
            r_int_addr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state      <= ST_ISSUE;
                        r_int_addr   <= w_winner;
                        r_interrupt  <= 1'b1;
                        r_in_service <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_state     <= ST_SERVICE;
                    r_interrupt <= 1'b0;
                end
                ST_SERVICE: begin
                    if (w_ret) begin
                        r_state      <= ST_GUARD;
                        r_in_service <= 1'b0;
                    end
                end
                ST_GUARD: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_interrupt  <= 1'b0;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    assign bus.interrupt  = r_interrupt;
    assign bus.in_service = r_in_service;
    assign bus.int_addr   = r_int_addr;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl: latency, priority, inhibits, no-nesting,
// set-wins pending, level sources and asynchronous reset.
module tb_int_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    int_ctrl_if #(.NUM_SRC(8)) bus ();

    int_ctrl #(
        .NUM_SRC     (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] addr, output logic [7:0] data);
        bus.cfg_addr = addr;
        #1;
        data = bus.cfg_rdata;
    endtask

    // Clocks until interrupt is seen or the budget runs out; returns edges waited
    task automatic wait_int(input int max_cyc, output int n);
        n = 0;
        while (!bus.interrupt && n < max_cyc) begin
            tick();
            n++;
        end
    endtask

    task automatic quiet(input int cyc, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (cyc) begin
            tick();
            if (bus.interrupt) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    task automatic do_ret();
        bus.RET = 1'b1;
        tick();
        chk("ret_in_service", 32'(bus.in_service), 32'd0);
        bus.RET = 1'b0;
        tick();
        chk("guard_no_int", 32'(bus.interrupt), 32'd0);
    endtask

    task automatic set_stall(input int k, input logic v);
        case (k)
            0:       bus.hazard         = v;
            1:       bus.p_cache_miss   = v;
            default: bus.pipeline_flush = v;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int         n;

        n_checks           = 0;
        n_errors           = 0;
        rst_n              = 1'b0;
        bus.irq_in         = '0;
        bus.cfg_we         = 1'b0;
        bus.cfg_addr       = '0;
        bus.cfg_wdata      = '0;
        bus.hazard         = 1'b0;
        bus.branch_hazard  = 1'b0;
        bus.pipeline_flush = 1'b0;
        bus.p_cache_miss   = 1'b0;
        bus.RET            = 1'b0;

        // Reset values
        repeat (2) tick();
        chk("rst_interrupt", 32'(bus.interrupt), 32'd0);
        chk("rst_in_service", 32'(bus.in_service), 32'd0);
        chk("rst_int_addr", 32'(bus.int_addr), 32'd0);
        for (int a = 0; a < 4; a++) begin
            cfg_read(2'(a), rd);
            chk($sformatf("rst_reg%0d", a), 32'(rd), 32'd0);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();

        // Single edge source 0: latency 4, one-cycle pulse, pending cleared
        cfg_write(2'd0, 8'h01);
        cfg_write(2'd1, 8'h01);
        cfg_write(2'd3, 8'h01);
        chk("pre_int", 32'(bus.interrupt), 32'd0);
        bus.irq_in[0] = 1'b1;
        wait_int(12, n);
        chk("lat_src0", 32'(n), 32'd4);
        chk("addr_src0", 32'(bus.int_addr), 32'd0);
        chk("svc_src0", 32'(bus.in_service), 32'd1);
        tick();
        chk("pulse_src0", 32'(bus.interrupt), 32'd0);
        cfg_read(2'd2, rd);
        chk("pend_src0", 32'(rd), 32'd0);
        bus.irq_in[0] = 1'b0;
        do_ret();

        // Simultaneous edges on 5 and 2: 2 first, 5 after return and guard
        cfg_write(2'd0, 8'hFF);
        cfg_write(2'd1, 8'hFF);
        bus.irq_in = 8'h24;
        wait_int(12, n);
        chk("lat_src2", 32'(n), 32'd4);
        chk("addr_src2", 32'(bus.int_addr), 32'd2);
        tick();
        bus.irq_in = 8'h00;
        do_ret();
        wait_int(12, n);
        chk("lat_src5", 32'(n), 32'd1);
        chk("addr_src5", 32'(bus.int_addr), 32'd5);
        tick();
        do_ret();

        // Each stall input blocks grant until the cycle after it drops
        for (int k = 0; k < 3; k++) begin
            set_stall(k, 1'b1);
            bus.irq_in[1] = 1'b1;
            quiet(10, $sformatf("stall%0d_block", k));
            set_stall(k, 1'b0);
            tick();
            chk($sformatf("stall%0d_grant", k), 32'(bus.interrupt), 32'd1);
            chk($sformatf("stall%0d_addr", k), 32'(bus.int_addr), 32'd1);
            bus.irq_in[1] = 1'b0;
            tick();
            do_ret();
        end

        // No nesting; RET ignored under branch_hazard
        bus.irq_in[6] = 1'b1;
        wait_int(12, n);
        chk("lat_src6", 32'(n), 32'd4);
        chk("addr_src6", 32'(bus.int_addr), 32'd6);
        tick();
        bus.irq_in[1] = 1'b1;
        quiet(5, "nest_block");
        cfg_read(2'd2, rd);
        chk("nest_pend", 32'(rd), 32'h02);
        bus.RET           = 1'b1;
        bus.branch_hazard = 1'b1;
        tick();
        chk("bh_ret_ignored", 32'(bus.in_service), 32'd1);
        bus.RET           = 1'b0;
        bus.branch_hazard = 1'b0;
        tick();
        chk("still_service", 32'(bus.in_service), 32'd1);
        bus.RET = 1'b1;
        tick();
        chk("ret_ok", 32'(bus.in_service), 32'd0);
        chk("guard_int", 32'(bus.interrupt), 32'd0);
        bus.RET = 1'b0;
        tick();
        chk("idle_int", 32'(bus.interrupt), 32'd0);
        tick();
        chk("nest_grant", 32'(bus.interrupt), 32'd1);
        chk("nest_addr", 32'(bus.int_addr), 32'd1);
        bus.irq_in = 8'h00;
        tick();
        do_ret();

        // Edge and W1C in the same cycle: set wins; plain W1C clears
        cfg_write(2'd3, 8'h00);
        bus.irq_in[3] = 1'b1;
        tick();
        tick();
        cfg_write(2'd2, 8'h08);
        cfg_read(2'd2, rd);
        chk("set_wins", 32'(rd), 32'h08);
        cfg_write(2'd2, 8'h08);
        cfg_read(2'd2, rd);
        chk("w1c_clear", 32'(rd), 32'h00);
        bus.irq_in[3] = 1'b0;

        // Level source 4 comes and goes before gie: never granted
        cfg_write(2'd1, 8'hEF);
        bus.irq_in[4] = 1'b1;
        repeat (4) tick();
        cfg_read(2'd2, rd);
        chk("level_high", 32'(rd), 32'h10);
        bus.irq_in[4] = 1'b0;
        repeat (4) tick();
        cfg_read(2'd2, rd);
        chk("level_low", 32'(rd), 32'h00);
        cfg_write(2'd3, 8'h01);
        quiet(6, "level_gone");

        // Asynchronous reset during service
        bus.irq_in[7] = 1'b1;
        wait_int(12, n);
        chk("lat_src7", 32'(n), 32'd4);
        chk("addr_src7", 32'(bus.int_addr), 32'd7);
        tick();
        chk("svc_src7", 32'(bus.in_service), 32'd1);
        bus.cfg_addr = 2'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_in_service", 32'(bus.in_service), 32'd0);
        chk("async_interrupt", 32'(bus.interrupt), 32'd0);
        chk("async_mask", 32'(bus.cfg_rdata), 32'd0);
        #3;
        rst_n = 1'b1;
        bus.irq_in = 8'h84;
        quiet(8, "post_rst_quiet");
        cfg_read(2'd3, rd);
        chk("post_rst_gie", 32'(rd), 32'd0);
        bus.irq_in = 8'h00;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
